// File: rtl/core_desc_scheduler_pkg.sv
// core_desc_scheduler_pkg: shared state encoding, descriptor width and credit sizing helper
package core_desc_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DESC_WIDTH = 64;

    function automatic int credit_width(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/core_desc_scheduler_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick of the first request at or after ptr
module rr_priority_pick
    import core_desc_scheduler_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any_valid
);

    logic [W-1:0] idx;

    // Scan farthest offset first so the nearest request at or after ptr wins last
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) grant = idx;
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/core_desc_scheduler.sv
// core_desc_scheduler: credit-based round-robin distribution of descriptors to cores
module core_desc_scheduler #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int SLOT_COUNT    = 32,
    parameter int CREDIT_WIDTH  = core_desc_scheduler_pkg::credit_width(SLOT_COUNT),
    parameter int DESC_WIDTH    = core_desc_scheduler_pkg::DESC_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DESC_WIDTH-1:0]              s_desc,
    input  logic                               s_desc_valid,
    output logic                               s_desc_ready,
    output logic [DESC_WIDTH-1:0]              m_desc,
    output logic [CORE_ID_WIDTH-1:0]           m_desc_core,
    output logic [CORE_COUNT-1:0]              m_desc_valid,
    input  logic [CORE_COUNT-1:0]              m_desc_ready,
    input  logic [CORE_COUNT-1:0]              slot_release,
    input  logic [CORE_COUNT-1:0]              core_enable,
    input  logic [CORE_COUNT-1:0]              core_flush,
    output logic [CORE_COUNT*CREDIT_WIDTH-1:0] credit_out,
    output logic                               desc_drop,
    output logic                               err_overflow
);
    import core_desc_scheduler_pkg::*;

    localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(SLOT_COUNT);

    state_t                    state, state_next;
    logic [CREDIT_WIDTH-1:0]   credit [CORE_COUNT];
    logic [CORE_ID_WIDTH-1:0]  rr_ptr, pick;
    logic [CORE_COUNT-1:0]     eligible, dec, ovf;
    logic                      any_elig, m_fire, accept, drop;

    rr_priority_pick #(.N(CORE_COUNT), .W(CORE_ID_WIDTH)) u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (pick),
        .any_valid (any_elig)
    );

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_core
        assign eligible[g] = core_enable[g] && credit[g] != '0;
        assign credit_out[g*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[g];
    end

    assign m_fire = state == SEND && m_desc_ready[m_desc_core];
    assign accept = s_desc_valid && s_desc_ready;
    assign drop   = state == SEND && !m_fire && !core_enable[m_desc_core];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: a new accept always (re)enters SEND, a delivery or discard empties the holder
    always_comb begin
        state_next = accept ? SEND : (m_fire || drop) ? IDLE : state;
    end

    // Handshake outputs: accept while empty, or in the same cycle the held descriptor is taken
    always_comb begin
        s_desc_ready = any_elig && (state == IDLE || m_fire);
        m_desc_valid = state == SEND ? {{(CORE_COUNT-1){1'b0}}, 1'b1} << m_desc_core : '0;
    end

    // Per-core credit decrement on accept and release saturation detection
    always_comb begin
        dec = '0;
        ovf = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            dec[i] = accept && pick == CORE_ID_WIDTH'(i);
            ovf[i] = !core_flush[i] && slot_release[i] && !dec[i] && credit[i] == FULL;
        end
    end

    // Held descriptor, destination, round-robin pointer and drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_desc      <= '0;
            m_desc_core <= '0;
            rr_ptr      <= '0;
            desc_drop   <= 1'b0;
        end else begin
            desc_drop <= drop;
            if (accept) begin
                m_desc      <= s_desc;
                m_desc_core <= pick;
                rr_ptr      <= pick == CORE_ID_WIDTH'(CORE_COUNT - 1) ? '0 : pick + 1'b1;
            end
        end
    end

    // Credit counters: flush wins, simultaneous take and release cancel, releases saturate at full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CORE_COUNT; i++) credit[i] <= FULL;
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= err_overflow || |ovf;
            for (int i = 0; i < CORE_COUNT; i++)
                credit[i] <= core_flush[i] ? FULL :
                             (dec[i] && !slot_release[i]) ? credit[i] - 1'b1 :
                             (slot_release[i] && !dec[i] && !ovf[i]) ? credit[i] + 1'b1 :
                             credit[i];
        end
    end

endmodule

// File: tb/tb_core_desc_scheduler.sv
// tb_core_desc_scheduler: scenario tasks plus randomized traffic against a slot-level reference model
module tb_core_desc_scheduler;
    localparam int N  = 8;
    localparam int CW = 6;
    localparam int DW = 64;
    localparam logic [N*CW-1:0] ALL_FULL = {N{6'd32}};

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_desc;
    logic            s_desc_valid;
    logic            s_desc_ready;
    logic [DW-1:0]   m_desc;
    logic [2:0]      m_desc_core;
    logic [N-1:0]    m_desc_valid;
    logic [N-1:0]    m_desc_ready;
    logic [N-1:0]    slot_release;
    logic [N-1:0]    core_enable;
    logic [N-1:0]    core_flush;
    logic [N*CW-1:0] credit_out;
    logic            desc_drop;
    logic            err_overflow;

    int total = 0;
    int passed = 0;

    int          mcred [N];
    int          mptr;
    bit          mheld;
    int          mcore;
    logic [63:0] mdesc;
    bit          merr;
    bit          mdrop;

    always #5 clk = ~clk;

    core_desc_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .s_desc       (s_desc),
        .s_desc_valid (s_desc_valid),
        .s_desc_ready (s_desc_ready),
        .m_desc       (m_desc),
        .m_desc_core  (m_desc_core),
        .m_desc_valid (m_desc_valid),
        .m_desc_ready (m_desc_ready),
        .slot_release (slot_release),
        .core_enable  (core_enable),
        .core_flush   (core_flush),
        .credit_out   (credit_out),
        .desc_drop    (desc_drop),
        .err_overflow (err_overflow)
    );

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (core_enable[idx] && mcred[idx] > 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_fire();
        return mheld && m_desc_ready[mcore];
    endfunction

    function automatic bit m_ready();
        return m_pick() >= 0 && (!mheld || m_fire());
    endfunction

    function automatic logic [N-1:0] m_valid();
        return mheld ? (8'b1 << mcore) : 8'b0;
    endfunction

    function automatic logic [N*CW-1:0] m_credits();
        logic [N*CW-1:0] r;
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(mcred[i]);
        return r;
    endfunction

    task automatic model_init();
        for (int i = 0; i < N; i++) mcred[i] = 32;
        mptr = 0; mheld = 0; mcore = 0; mdesc = '0; merr = 0; mdrop = 0;
    endtask

    task automatic tick();
        int p;
        bit fire, acc, drop;
        p    = m_pick();
        fire = m_fire();
        acc  = s_desc_valid && m_ready();
        drop = mheld && !fire && !core_enable[mcore];
        for (int i = 0; i < N; i++) begin
            bit dec;
            dec = acc && p == i;
            if (core_flush[i]) mcred[i] = 32;
            else if (slot_release[i] && !dec && mcred[i] == 32) merr = 1;
            else mcred[i] = mcred[i] + int'(slot_release[i]) - int'(dec);
        end
        if (acc) begin
            mheld = 1; mdesc = s_desc; mcore = p; mptr = (p + 1) % N;
        end else if (fire || drop) mheld = 0;
        mdrop = drop;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_desc = '0; s_desc_valid = 0; m_desc_ready = '1; slot_release = '0;
        core_enable = '1; core_flush = '0;
        model_init();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        m_desc_ready = '0;
        s_desc_valid = 1; s_desc = 64'h1234_5678_9ABC_DEF0;
        tick();
        s_desc_valid = 0;
        #1;
        total++;
        if (m_desc_valid !== 8'h01) $display("FAIL reset_pre_send: m_desc_valid=%h want 01", m_desc_valid);
        else passed++;
        rst = 1'b1;
        model_init();
        #1;
        total++;
        if (m_desc_valid !== 8'h00 || m_desc !== 64'h0 || m_desc_core !== 3'd0)
            $display("FAIL reset_outputs: valid=%h desc=%h core=%0d want 00/0/0", m_desc_valid, m_desc, m_desc_core);
        else passed++;
        total++;
        if (credit_out !== ALL_FULL || desc_drop !== 1'b0 || err_overflow !== 1'b0)
            $display("FAIL reset_credits: credit=%h drop=%b err=%b want %h/0/0", credit_out, desc_drop, err_overflow, ALL_FULL);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        m_desc_ready = '1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            s_desc_valid = c < 8;
            s_desc = {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL rr_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            if (c > 0) begin
                total++;
                if (m_desc_valid !== (8'b1 << (c - 1)) || m_desc !== mdesc)
                    $display("FAIL rr_order: valid=%h desc=%h want %h/%h", m_desc_valid, m_desc, 8'b1 << (c - 1), mdesc);
                else passed++;
            end
            tick();
        end
        s_desc_valid = 0;
        total++;
        if (credit_out !== {N{6'd31}} || credit_out !== m_credits())
            $display("FAIL rr_credits: credit=%h want %h", credit_out, {N{6'd31}});
        else passed++;
        s_desc_valid = 1;
        tick();
        s_desc_valid = 0;
        #1;
        total++;
        if (m_desc_valid !== 8'h01) $display("FAIL rr_wrap: m_desc_valid=%h want 01", m_desc_valid);
        else passed++;
        tick();
    endtask

    task automatic test_enable_mask();
        do_reset();
        core_enable = 8'hAA;
        for (int c = 0; c < 5; c++) begin
            s_desc_valid = c < 4;
            s_desc = {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL mask_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            tick();
        end
        s_desc_valid = 0;
        total++;
        if (credit_out !== {4{6'd31, 6'd32}} || credit_out !== m_credits())
            $display("FAIL mask_credits: credit=%h want %h", credit_out, {4{6'd31, 6'd32}});
        else passed++;
    endtask

    task automatic test_credit_exhaust();
        int delivered = 0;
        do_reset();
        core_enable = 8'h01;
        s_desc_valid = 1;
        for (int c = 0; c < 34; c++) begin
            s_desc = {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL exhaust_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            if (m_desc_valid[0] && m_desc_ready[0]) delivered++;
            tick();
        end
        #1;
        total++;
        if (delivered !== 32 || s_desc_ready !== 1'b0 || credit_out[0 +: CW] !== 6'd0)
            $display("FAIL exhaust_stop: delivered=%0d ready=%b credit=%0d want 32/0/0", delivered, s_desc_ready, credit_out[0 +: CW]);
        else passed++;
        s_desc_valid = 0;
        slot_release = 8'h01;
        tick();
        slot_release = '0;
        #1;
        total++;
        if (s_desc_ready !== 1'b1 || s_desc_ready !== m_ready())
            $display("FAIL exhaust_release: ready=%b want 1", s_desc_ready);
        else passed++;
        s_desc_valid = 1;
        tick();
        s_desc_valid = 0;
        #1;
        if (m_desc_valid[0] && m_desc_ready[0]) delivered++;
        total++;
        if (delivered !== 33) $display("FAIL exhaust_33rd: delivered=%0d want 33", delivered);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] nxt;
        do_reset();
        m_desc_ready = 8'hFB;
        s_desc_valid = 1;
        for (int c = 0; c < 3; c++) begin
            s_desc = c == 2 ? 64'hDEAD : {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL bp_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            tick();
        end
        nxt = {$urandom, $urandom};
        s_desc = nxt;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (m_desc !== 64'hDEAD || m_desc_core !== 3'd2 || s_desc_ready !== 1'b0 || m_desc_valid !== 8'h04)
                $display("FAIL bp_hold: desc=%h core=%0d ready=%b valid=%h want dead/2/0/04", m_desc, m_desc_core, s_desc_ready, m_desc_valid);
            else passed++;
            tick();
        end
        m_desc_ready = '1;
        #1;
        total++;
        if (s_desc_ready !== 1'b1) $display("FAIL bp_release_ready: ready=%b want 1", s_desc_ready);
        else passed++;
        tick();
        s_desc_valid = 0;
        total++;
        if (m_desc !== nxt || m_desc_core !== 3'd3 || m_desc !== mdesc)
            $display("FAIL bp_next: desc=%h core=%0d want %h/3", m_desc, m_desc_core, nxt);
        else passed++;
        tick();
    endtask

    task automatic test_credit_overflow();
        do_reset();
        core_enable = 8'h08;
        s_desc_valid = 1;
        for (int c = 0; c < 12; c++) begin
            s_desc = {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL ovf_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            tick();
        end
        total++;
        if (credit_out[3*CW +: CW] !== 6'd20) $display("FAIL ovf_pre20: credit3=%0d want 20", credit_out[3*CW +: CW]);
        else passed++;
        slot_release = 8'h08;
        tick();
        slot_release = '0;
        s_desc_valid = 0;
        total++;
        if (credit_out[3*CW +: CW] !== 6'd20 || credit_out !== m_credits())
            $display("FAIL ovf_simul: credit3=%0d want 20", credit_out[3*CW +: CW]);
        else passed++;
        total++;
        if (err_overflow !== 1'b0) $display("FAIL ovf_clean: err=%b want 0", err_overflow);
        else passed++;
        slot_release = 8'h20;
        tick();
        slot_release = '0;
        total++;
        if (credit_out[5*CW +: CW] !== 6'd32 || err_overflow !== 1'b1)
            $display("FAIL ovf_set: credit5=%0d err=%b want 32/1", credit_out[5*CW +: CW], err_overflow);
        else passed++;
        tick();
        tick();
        total++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_sticky: err=%b want 1", err_overflow);
        else passed++;
    endtask

    task automatic test_disable_drop();
        do_reset();
        m_desc_ready = 8'hEF;
        s_desc_valid = 1;
        for (int c = 0; c < 5; c++) begin
            s_desc = {$urandom, $urandom};
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL drop_handshake: ready=%b valid=%h want %b/%h", s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            tick();
        end
        s_desc_valid = 0;
        #1;
        total++;
        if (m_desc_valid !== 8'h10 || desc_drop !== 1'b0)
            $display("FAIL drop_held: valid=%h drop=%b want 10/0", m_desc_valid, desc_drop);
        else passed++;
        core_enable = 8'hEF;
        tick();
        core_enable = '1;
        total++;
        if (desc_drop !== 1'b1 || m_desc_valid !== 8'h00 || credit_out[4*CW +: CW] !== 6'd31)
            $display("FAIL drop_pulse: drop=%b valid=%h credit4=%0d want 1/00/31", desc_drop, m_desc_valid, credit_out[4*CW +: CW]);
        else passed++;
        core_flush = 8'h10;
        tick();
        core_flush = '0;
        total++;
        if (desc_drop !== 1'b0 || credit_out[4*CW +: CW] !== 6'd32 || credit_out !== m_credits())
            $display("FAIL drop_flush: drop=%b credit4=%0d want 0/32", desc_drop, credit_out[4*CW +: CW]);
        else passed++;
        m_desc_ready = '1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s_desc_valid = $urandom_range(0, 3) != 0;
            s_desc       = {$urandom, $urandom};
            m_desc_ready = N'($urandom | $urandom);
            core_enable  = $urandom_range(0, 15) == 0 ? N'($urandom) : 8'hFF;
            slot_release = N'($urandom & $urandom & $urandom);
            core_flush   = $urandom_range(0, 31) == 0 ? (8'b1 << $urandom_range(0, 7)) : 8'h00;
            #1;
            total++;
            if (s_desc_ready !== m_ready() || m_desc_valid !== m_valid())
                $display("FAIL rand_handshake: cyc=%0d ready=%b valid=%h want %b/%h", c, s_desc_ready, m_desc_valid, m_ready(), m_valid());
            else passed++;
            if (mheld) begin
                total++;
                if (m_desc !== mdesc || m_desc_core !== 3'(mcore))
                    $display("FAIL rand_desc: cyc=%0d desc=%h core=%0d want %h/%0d", c, m_desc, m_desc_core, mdesc, mcore);
                else passed++;
            end
            tick();
            total++;
            if (credit_out !== m_credits() || err_overflow !== merr || desc_drop !== mdrop)
                $display("FAIL rand_state: cyc=%0d credit=%h err=%b drop=%b want %h/%b/%b", c, credit_out, err_overflow, desc_drop, m_credits(), merr, mdrop);
            else passed++;
        end
        s_desc_valid = 0; slot_release = '0; core_flush = '0; core_enable = '1; m_desc_ready = '1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_enable_mask();
        test_credit_exhaust();
        test_backpressure();
        test_credit_overflow();
        test_disable_drop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_desc_scheduler.md
Name: core_desc_scheduler

Overview:
Distributes incoming packet descriptors from the ingress path to the per-core descriptor inputs, one per RISC-V core wrapper (in_desc/in_desc_valid/in_desc_taken). Keeps a slot-credit counter per core, initialised to SLOT_COUNT. Sends each descriptor to the next eligible core in round-robin order. Returns a credit when a core releases a slot.
Sits between the ingress descriptor FIFO and the array of core wrappers.

Parameters:
CORE_COUNT, 8, number of cores served
CORE_ID_WIDTH, 3, width of the core index; must equal $clog2(CORE_COUNT)
SLOT_COUNT, 32, packet slots per core
CREDIT_WIDTH, $clog2(SLOT_COUNT+1), width of each credit counter
DESC_WIDTH, 64, descriptor width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_desc  in  DESC_WIDTH  incoming descriptor
s_desc_valid  in  1  incoming descriptor valid
s_desc_ready  out  1  descriptor accepted when high together with valid
m_desc  out  DESC_WIDTH  held descriptor, shared by all cores
m_desc_core  out  CORE_ID_WIDTH  index of the destination core
m_desc_valid  out  CORE_COUNT  one-hot valid per core
m_desc_ready  in  CORE_COUNT  per-core taken
slot_release  in  CORE_COUNT  one-cycle pulse per core; returns one credit
core_enable  in  CORE_COUNT  core may be selected
core_flush  in  CORE_COUNT  pulse; sets that core's credit to SLOT_COUNT
credit_out  out  CORE_COUNT*CREDIT_WIDTH  current credits; core i is at bits [i*CREDIT_WIDTH +: CREDIT_WIDTH]
desc_drop  out  1  one-cycle pulse when a held descriptor is discarded
err_overflow  out  1  sticky; set on a release while credit==SLOT_COUNT

Behaviour:
- Reset (asynchronous, rst high):
  - state=IDLE, rr_ptr=0, all credits=SLOT_COUNT.
  - m_desc=0, m_desc_core=0, m_desc_valid=0.
  - desc_drop=0, err_overflow=0.
- eligible[i] = core_enable[i] && credit[i]!=0, using registered credits only.
- pick = first eligible index at or after rr_ptr, searching cyclically. any_elig = |eligible.
- States:
  - IDLE: s_desc_ready=any_elig.
  - SEND: s_desc_ready = any_elig && m_fire, where m_fire = m_desc_ready[m_desc_core].
- Accept (s_desc_valid && s_desc_ready):
  - m_desc<=s_desc, m_desc_core<=pick.
  - credit[pick] decrements.
  - rr_ptr<=(pick+1) mod CORE_COUNT.
  - state<=SEND.
- Latency: descriptor accepted in cycle N appears on m_desc_valid in cycle N+1.
- SEND:
  - m_desc_valid = one-hot(m_desc_core).
  - m_fire with no new accept -> IDLE.
  - m_fire with a new accept -> stay in SEND with the new descriptor. This gives 1 descriptor/cycle throughput.
  - m_desc and m_desc_core stay stable until m_fire.
- Disable mid-send: core_enable[m_desc_core] low in SEND without m_fire:
  - descriptor discarded, desc_drop pulses, state<=IDLE.
  - credit is not restored; software issues core_flush.
- Credit update per core, same cycle, with dec=accept to i and inc=slot_release[i]:
  - flush: credit<=SLOT_COUNT; dec and inc are ignored.
  - otherwise credit<=credit-dec+inc; simultaneous dec and inc leaves credit unchanged.
  - inc when credit==SLOT_COUNT and no dec: credit saturates and err_overflow is set.
  - dec never occurs at credit 0, because eligibility excludes it.
- Flush during SEND to the same core: the held descriptor is still delivered and does not decrement again.
- Reset mid-SEND: descriptor lost and m_desc_valid drops immediately. The upstream FIFO is reset by the same rst.
- credit_out is registered and reflects post-update values one cycle after each event.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=1'b0, SEND=1'b1)
  - DESC_WIDTH
  - a CREDIT_WIDTH computing function reused by other slot-tracking blocks
- One sub-module: rr_priority_pick. It is purely combinational: inputs req[CORE_COUNT] and ptr; outputs grant index and any_valid. It is reused by the broadcast-message arbiter.

Test Plan:
- Reset, then 8 back-to-back descriptors with all m_desc_ready=1 -> cores 0..7 in order, one per cycle; each credit 31; rr_ptr=0.
- core_enable=8'b1010_1010, 4 descriptors -> cores 1,3,5,7; cores 0,2,4,6 credits remain 32.
- Core 0 only enabled, 32 descriptors, no release -> 32 delivered, then s_desc_ready=0. One slot_release[0] -> ready 1 cycle later; 33rd delivered.
- Hold m_desc_ready[2]=0 for 5 cycles with descriptor 0xDEAD to core 2 -> m_desc stays 0xDEAD and s_desc_ready=0 throughout. Release ready -> taken; next accept the same cycle.
- Accept to core 3 with slot_release[3] in the same cycle at credit 20 -> credit stays 20. slot_release[5] at credit 32 -> credit 32, err_overflow=1 (sticky).
- Deassert core_enable[4] while SEND to core 4 -> desc_drop pulse, m_desc_valid=0, credit[4]=31. core_flush[4] -> credit 32.
